// File: rtl/mem_responder.sv
// mem_responder: target end of the MRD/MWR strobe memory interface.
// Wait-state stall, one-cycle RDY, protocol error pulses, access counter.
module mem_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter bit ALT_CHECK   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MRD,
  input  logic              MWR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  output logic              RDY,
  output logic              ERR_COLL,
  output logic              ERR_ABORT,
  output logic              SEQ_ERR,
  output logic [15:0]       ACC_CNT
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    T_NONE,
    T_RD,
    T_WR
  } acc_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  acc_t              typ_q, typ_d;
  acc_t              last_q, last_d;

  logic rdy_d, coll_d, abort_d, seq_d, oe_d;
  logic rd_en, wr_en, drop;

  // latched strobe lost or opposite strobe raised while stalling
  assign drop = (typ_q == T_RD) ? (!MRD || MWR)
                                : (!MWR || MRD);

  // next-state, pulse and enable decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    typ_d   = typ_q;
    last_d  = last_q;
    rdy_d   = 1'b0;
    coll_d  = 1'b0;
    abort_d = 1'b0;
    seq_d   = 1'b0;
    oe_d    = DATA_OE;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          (MRD && MWR): begin
            coll_d  = 1'b1;
            state_d = S_HOLD;
          end
          (MRD ^ MWR): begin
            addr_d  = ADDR;
            typ_d   = MRD ? T_RD : T_WR;
            cnt_d   = WS;
            state_d = (WS == 4'd0) ? S_ACCESS
                                   : S_WAIT;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (drop) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        rdy_d   = 1'b1;
        rd_en   = (typ_q == T_RD);
        wr_en   = (typ_q == T_WR);
        oe_d    = (typ_q == T_RD) || DATA_OE;
        seq_d   = ALT_CHECK && (last_q == typ_q);
        last_d  = typ_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!MRD && !MWR) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control state, pulses and saturating access counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      typ_q     <= T_NONE;
      last_q    <= T_NONE;
      RDY       <= 1'b0;
      ERR_COLL  <= 1'b0;
      ERR_ABORT <= 1'b0;
      SEQ_ERR   <= 1'b0;
      DATA_OE   <= 1'b0;
      ACC_CNT   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr_q    <= addr_d;
      typ_q     <= typ_d;
      last_q    <= last_d;
      RDY       <= rdy_d;
      ERR_COLL  <= coll_d;
      ERR_ABORT <= abort_d;
      SEQ_ERR   <= seq_d;
      DATA_OE   <= oe_d;
      if (rdy_d && (ACC_CNT != 16'hFFFF)) begin
        ACC_CNT <= ACC_CNT + 16'd1;
      end
    end
  end

  // read data register, loaded on the access edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DATA_OUT <= '0;
    end else if (rd_en) begin
      DATA_OUT <= mem[addr_q];
    end
  end

  // storage array; contents survive reset, commit suppressed by it
  always_ff @(posedge CLK) begin
    if (RST_N && wr_en) begin
      mem[addr_q] <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responder configs driven in lockstep,
// each compared against a transaction-level memory/protocol model.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam int WSV  [NDUT] = '{1, 0, 3};
  localparam bit ALTV [NDUT] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mrd, mwr;
  logic [6:0]  addr;
  logic [15:0] din;

  logic [15:0] dout [NDUT];
  logic        oe   [NDUT];
  logic        rdy  [NDUT];
  logic        coll [NDUT];
  logic        abt  [NDUT];
  logic        seq  [NDUT];
  logic [15:0] acc  [NDUT];

  logic [15:0] mdl_mem [NDUT][128];
  int          last_t  [NDUT];
  int          mcnt    [NDUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(7),
      .DATA_W(16),
      .WAIT_STATES(WSV[g]),
      .ALT_CHECK(ALTV[g])
    ) u_dut (
      .CLK(clk),
      .RST_N(rst_n),
      .MRD(mrd),
      .MWR(mwr),
      .ADDR(addr),
      .DATA_IN(din),
      .DATA_OUT(dout[g]),
      .DATA_OE(oe[g]),
      .RDY(rdy[g]),
      .ERR_COLL(coll[g]),
      .ERR_ABORT(abt[g]),
      .SEQ_ERR(seq[g]),
      .ACC_CNT(acc[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string when);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("%s d%0d rdy", when, i), 32'(rdy[i]), 0);
      chk($sformatf("%s d%0d oe", when, i), 32'(oe[i]), 0);
      chk($sformatf("%s d%0d dout", when, i), 32'(dout[i]), 0);
      chk($sformatf("%s d%0d coll", when, i), 32'(coll[i]), 0);
      chk($sformatf("%s d%0d abort", when, i), 32'(abt[i]), 0);
      chk($sformatf("%s d%0d seq", when, i), 32'(seq[i]), 0);
      chk($sformatf("%s d%0d acc", when, i), 32'(acc[i]), 0);
    end
  endtask

  // typ: 1 read, 2 write, 3 both strobes; strobe high for h edges
  task automatic run_txn(input int typ, input logic [6:0] a,
                         input int h, input logic [15:0] d,
                         input bit rnd);
    int          n;
    logic [15:0] dat [8];
    int          rdy_n [NDUT];
    int          rdy_j [NDUT];
    int          col_n [NDUT];
    int          col_j [NDUT];
    int          ab_n  [NDUT];
    int          ab_j  [NDUT];
    int          sq_n  [NDUT];
    logic [15:0] dq    [NDUT];
    logic        oeq   [NDUT];
    int          ws;
    int          xs;
    n = ((h > 5) ? h : 5) + 1 + int'($urandom_range(0, 1));
    for (int j = 0; j < 8; j++) begin
      dat[j] = rnd ? 16'($urandom) : d;
    end
    for (int i = 0; i < NDUT; i++) begin
      rdy_n[i] = 0; rdy_j[i] = -1;
      col_n[i] = 0; col_j[i] = -1;
      ab_n[i]  = 0; ab_j[i]  = -1;
      sq_n[i]  = 0; dq[i] = '0; oeq[i] = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      mrd  = (j < h) && (typ != 2);
      mwr  = (j < h) && (typ != 1);
      addr = (j == 0) ? a : 7'($urandom);
      din  = dat[j];
      @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        if (rdy[i]) begin
          rdy_n[i]++; rdy_j[i] = j;
          dq[i] = dout[i]; oeq[i] = oe[i];
        end
        if (coll[i]) begin col_n[i]++; col_j[i] = j; end
        if (abt[i])  begin ab_n[i]++;  ab_j[i]  = j; end
        if (seq[i])  sq_n[i]++;
      end
    end
    mrd = 1'b0;
    mwr = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      ws = WSV[i];
      if (typ == 3) begin
        chk($sformatf("d%0d coll_n", i), col_n[i], 1);
        chk($sformatf("d%0d coll_edge", i), col_j[i], 0);
        chk($sformatf("d%0d coll_rdy", i), rdy_n[i], 0);
        chk($sformatf("d%0d coll_abort", i), ab_n[i], 0);
        chk($sformatf("d%0d coll_seq", i), sq_n[i], 0);
      end else if (ws > 0 && h <= ws) begin
        chk($sformatf("d%0d abort_n", i), ab_n[i], 1);
        chk($sformatf("d%0d abort_edge", i), ab_j[i], h);
        chk($sformatf("d%0d abort_rdy", i), rdy_n[i], 0);
        chk($sformatf("d%0d abort_coll", i), col_n[i], 0);
        chk($sformatf("d%0d abort_seq", i), sq_n[i], 0);
      end else begin
        xs = (ALTV[i] && last_t[i] == typ) ? 1 : 0;
        chk($sformatf("d%0d rdy_n", i), rdy_n[i], 1);
        chk($sformatf("d%0d rdy_edge", i), rdy_j[i], ws + 1);
        chk($sformatf("d%0d acc_abort", i), ab_n[i], 0);
        chk($sformatf("d%0d acc_coll", i), col_n[i], 0);
        chk($sformatf("d%0d seq", i), sq_n[i], xs);
        if (typ == 1) begin
          chk($sformatf("d%0d rdata a%0d", i, a), 32'(dq[i]),
              32'(mdl_mem[i][a]));
          chk($sformatf("d%0d rd_oe", i), 32'(oeq[i]), 1);
        end else begin
          mdl_mem[i][a] = dat[ws + 1];
          chk($sformatf("d%0d wr_oe", i), 32'(oeq[i]), 0);
        end
        last_t[i] = typ;
        if (mcnt[i] < 65535) mcnt[i]++;
      end
      chk($sformatf("d%0d oe_end", i), 32'(oe[i]), 0);
      chk($sformatf("d%0d acc_cnt", i), 32'(acc[i]), mcnt[i]);
    end
  endtask

  // reset lands one edge into a write of address 4
  task automatic mid_reset();
    mrd  = 1'b0;
    mwr  = 1'b1;
    addr = 7'd4;
    din  = 16'($urandom);
    @(posedge clk);
    #1;
    din   = ~din;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    mwr   = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      last_t[i] = 0;
      mcnt[i]   = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int r;
    rst_n = 1'b0;
    mrd   = 1'b0;
    mwr   = 1'b0;
    addr  = '0;
    din   = '0;
    for (int i = 0; i < NDUT; i++) begin
      last_t[i] = 0;
      mcnt[i]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int a = 0; a < 128; a++) begin
      run_txn(2, 7'(a), 4, 16'h0, 1'b1);
    end

    run_txn(2, 7'd7, 4, 16'hA5A5, 1'b0);
    run_txn(1, 7'd7, 4, 16'h0, 1'b1);
    run_txn(2, 7'd3, 4, 16'h1234, 1'b0);
    run_txn(1, 7'd3, 2, 16'h0, 1'b1);
    run_txn(3, 7'd5, 3, 16'hDEAD, 1'b0);
    run_txn(1, 7'd5, 4, 16'h0, 1'b1);
    run_txn(2, 7'd9, 2, 16'hFFFF, 1'b0);
    run_txn(1, 7'd9, 4, 16'h0, 1'b1);
    run_txn(2, 7'd1, 4, 16'h1111, 1'b0);
    run_txn(2, 7'd2, 5, 16'h2222, 1'b0);
    run_txn(1, 7'd1, 4, 16'h0, 1'b1);
    run_txn(1, 7'd2, 4, 16'h0, 1'b1);

    mid_reset();
    run_txn(1, 7'd4, 4, 16'h0, 1'b1);

    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 9));
      run_txn((r < 4) ? 1 : (r < 8) ? 2 : 3,
              7'($urandom),
              int'($urandom_range(1, 6)),
              16'h0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
